// File: rtl/ws2811_multichannel_driver.sv
// ws2811_multichannel_driver: drives CHANNELS WS2811 strings in lockstep from one pixel-fetch port.
// Ports: clock, reset (async, active high); enable/led_count/speed_sel request and shape frames;
// pix_rd/pix_addr/pix_data fetch one 24-bit word per channel per LED from a 1-cycle-latency RAM;
// serial are the WS2811 data lines; busy spans frame start to end of latch; frame_done pulses
// on the last latch cycle.
module ws2811_multichannel_driver #(
  parameter int CHANNELS  = 4,
  parameter int MAX_LEDS  = 256,
  parameter int T0H_CYC   = 13,
  parameter int T1H_CYC   = 30,
  parameter int TBIT_CYC  = 62,
  parameter int RESET_CYC = 2800
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [$clog2(MAX_LEDS):0]   led_count,
  input  logic                        speed_sel,
  output logic                        pix_rd,
  output logic [$clog2(MAX_LEDS)-1:0] pix_addr,
  input  logic [24*CHANNELS-1:0]      pix_data,
  output logic [CHANNELS-1:0]         serial,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int LED_W  = $clog2(MAX_LEDS) + 1;
  localparam int ADDR_W = $clog2(MAX_LEDS);
  localparam int CW     = $clog2(2 * TBIT_CYC);
  localparam int RW     = $clog2(RESET_CYC + 1);
  localparam logic [CW-1:0] TB_F = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] TB_S = CW'(2 * TBIT_CYC - 1);
  localparam logic [CW-1:0] T0_F = CW'(T0H_CYC);
  localparam logic [CW-1:0] T0_S = CW'(2 * T0H_CYC);
  localparam logic [CW-1:0] T1_F = CW'(T1H_CYC);
  localparam logic [CW-1:0] T1_S = CW'(2 * T1H_CYC);
  typedef enum logic [1:0] {IDLE, PREFETCH, SEND, LATCH} state_t;
  state_t state, state_nx;
  logic [LED_W-1:0] n;
  logic slow;
  logic [ADDR_W-1:0] led_idx;
  logic [4:0] bit_idx;
  logic [CW-1:0] cyc;
  logic [RW-1:0] lat;
  logic fetch_q;
  logic [CHANNELS-1:0][23:0] shreg, hold;
  logic start, rd, bit_end, last_bit, last_led, lat_end;
  logic [CW-1:0] t0, t1;
  always_comb begin
    start    = enable && led_count != '0;
    bit_end  = cyc == (slow ? TB_S : TB_F);
    last_bit = bit_idx == 5'd0;
    last_led = {1'b0, led_idx} == n - LED_W'(1);
    lat_end  = lat == RW'(RESET_CYC - 1);
    t0       = slow ? T0_S : T0_F;
    t1       = slow ? T1_S : T1_F;
  end
  always_comb begin
    state_nx = state;
    rd       = 1'b0;
    pix_addr = '0;
    case (state)
      IDLE: begin
        rd       = start;
        state_nx = start ? PREFETCH : IDLE;
      end
      PREFETCH: state_nx = SEND;
      SEND: begin
        // fetch the next LED at the start of the current LED's final bit so it is ready at the boundary
        rd       = last_bit && cyc == '0 && !last_led;
        pix_addr = rd ? led_idx + ADDR_W'(1) : '0;
        state_nx = bit_end && last_bit && last_led ? LATCH : SEND;
      end
      LATCH: state_nx = lat_end ? IDLE : LATCH;
      default: state_nx = IDLE;
    endcase
  end
  // reset gates the combinational outputs so they drop without waiting for a clock edge
  always_comb begin
    pix_rd     = rd && !reset;
    busy       = state != IDLE || (start && !reset);
    frame_done = state == LATCH && lat_end;
    for (int c = 0; c < CHANNELS; c++)
      serial[c] = state == SEND && cyc < (shreg[c][23] ? t1 : t0);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      n       <= '0;
      slow    <= 1'b0;
      led_idx <= '0;
      bit_idx <= '0;
      cyc     <= '0;
      lat     <= '0;
      fetch_q <= 1'b0;
      shreg   <= '0;
      hold    <= '0;
    end else begin
      state   <= state_nx;
      fetch_q <= rd;
      lat     <= state == LATCH ? lat + RW'(1) : '0;
      if (fetch_q) hold <= pix_data;
      if (state == IDLE && start) begin
        n    <= led_count > LED_W'(MAX_LEDS) ? LED_W'(MAX_LEDS) : led_count;
        slow <= speed_sel;
      end
      if (state == PREFETCH) begin
        shreg   <= pix_data;
        led_idx <= '0;
        bit_idx <= 5'd23;
        cyc     <= '0;
      end
      if (state == SEND) begin
        cyc <= bit_end ? '0 : cyc + CW'(1);
        if (bit_end) begin
          bit_idx <= last_bit ? 5'd23 : bit_idx - 5'd1;
          if (last_bit) begin
            led_idx <= led_idx + ADDR_W'(1);
            shreg   <= hold;
          end else begin
            for (int c = 0; c < CHANNELS; c++)
              shreg[c] <= {shreg[c][22:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ws2811_multichannel_driver.sv
// tb_ws2811_multichannel_driver: table-driven frame checks plus hand-written corner sequences
module tb_ws2811_multichannel_driver;
  localparam int CH = 4, ML = 256, T0 = 1, T1 = 3, TBIT = 4, RST = 30;
  logic clock = 0, reset = 0, enable = 0, speed_sel = 0;
  logic [8:0] led_count = '0;
  logic pix_rd, busy, frame_done;
  logic [7:0] pix_addr;
  logic [24*CH-1:0] pix_data = '0;
  logic [CH-1:0] serial;
  logic [23:0] mem [CH][ML];
  int total = 0, bad = 0;
  typedef struct {
    logic [8:0]  cnt;
    logic        spd;
    int          n;
    int          tb;
    int          len;
    logic [95:0] w0;
  } vec_t;
  vec_t vecs [4];

  always #5 clock = ~clock;

  ws2811_multichannel_driver #(
    .CHANNELS(CH), .MAX_LEDS(ML), .T0H_CYC(T0), .T1H_CYC(T1), .TBIT_CYC(TBIT), .RESET_CYC(RST)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .led_count(led_count), .speed_sel(speed_sel),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data), .serial(serial),
    .busy(busy), .frame_done(frame_done)
  );

  // synchronous-read pixel RAM; data is garbage except the cycle after a read
  always @(posedge clock)
    for (int c = 0; c < CH; c++)
      pix_data[24*c +: 24] <= pix_rd ? mem[c][pix_addr] : 24'h3C3C3C;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input int n, input int tb, input int len, input int mid,
                           input bit pulse, output int w);
    int t, fetches, errs, nbits, k, exp_hi;
    int hi [CH], rises [CH], falls [CH];
    logic [CH-1:0] prev;
    bit done;
    t = 0; fetches = 0; errs = 0; w = 0; prev = '0; done = 0;
    for (int c = 0; c < CH; c++) begin hi[c] = 0; rises[c] = 0; falls[c] = 0; end
    @(negedge clock);
    while (!pix_rd && w < 8) begin w++; @(negedge clock); end
    while (!done && t <= len + 8) begin
      if (pix_rd) begin
        if (int'(pix_addr) != fetches ||
            t != (fetches == 0 ? 0 : 2 + ((fetches - 1) * 24 + 23) * tb)) errs++;
        fetches++;
      end
      if (!busy) errs++;
      for (int c = 0; c < CH; c++) begin
        if (serial[c]) begin
          if (!prev[c]) begin
            if (t != 2 + rises[c] * tb) errs++;
            rises[c]++;
          end
          hi[c]++;
          if (t > 1 + n * 24 * tb) errs++;
        end else if (prev[c]) begin
          k = falls[c];
          if (k < n * 24) begin
            exp_hi = (mem[c][k / 24][23 - k % 24] ? T1 : T0) * (tb / TBIT);
            if (hi[c] != exp_hi) errs++;
          end else errs++;
          falls[c]++;
          hi[c] = 0;
        end
      end
      prev = serial;
      done = frame_done;
      if (!done) begin
        if (pulse && t == 0) begin @(posedge clock); #1 enable = 0; end
        if (mid >= 0 && pix_rd && int'(pix_addr) == mid) begin
          @(posedge clock); #1 enable = 0; speed_sel = ~speed_sel; led_count = 9'd2;
        end
        t++;
        @(negedge clock);
      end
    end
    check("frame_len", done ? t : -1, len);
    check("fetches", fetches, n);
    nbits = 0;
    for (int c = 0; c < CH; c++) nbits += rises[c] + falls[c];
    check("bit_edges", nbits, 2 * CH * 24 * n);
    check("frame_errs", errs, 0);
  endtask

  initial begin
    int w, zr;
    for (int a = 0; a < ML; a++)
      for (int c = 0; c < CH; c++)
        mem[c][a] = 24'((a + 1) * 40503 + c * 7919) ^ 24'h5A0F35;
    vecs[0] = '{9'd1, 1'b0, 1, 4, 1 + 1 * 96 + RST,
                {24'hA5A5A5, 24'h0000FF, 24'h00FF00, 24'hFF0000}};
    vecs[1] = '{9'd2, 1'b1, 2, 8, 1 + 2 * 192 + RST,
                {24'h123456, 24'h800001, 24'hFFFFFF, 24'h000000}};
    vecs[2] = '{9'd5, 1'b0, 5, 4, 1 + 5 * 96 + RST,
                {24'hC3C3C3, 24'h0F0F0F, 24'hF0F0F0, 24'h3C3C3D}};
    vecs[3] = '{9'd3, 1'b1, 3, 8, 1 + 3 * 192 + RST,
                {24'h555555, 24'hAAAAAA, 24'h7E7E7E, 24'h818181}};
    #2 reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_rd", pix_rd, 0);
    check("rst_serial", int'(serial), 0);
    check("rst_done", frame_done, 0);
    check("rst_addr", int'(pix_addr), 0);
    @(posedge clock); #1 reset = 0; led_count = 9'd0; enable = 1;
    zr = 0;
    repeat (20) begin
      @(negedge clock);
      zr += int'(busy) + int'(pix_rd) + int'(serial != 0) + int'(frame_done);
    end
    check("zero_leds", zr, 0);
    @(posedge clock); #1 enable = 0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < CH; c++) mem[c][0] = vecs[i].w0[24*c +: 24];
      @(posedge clock); #1 led_count = vecs[i].cnt; speed_sel = vecs[i].spd; enable = 1;
      run_frame(vecs[i].n, vecs[i].tb, vecs[i].len, -1, 1, w);
      check("start_wait", w, 0);
      @(negedge clock);
      check("idle_busy", busy, 0);
      check("idle_rd", pix_rd, 0);
    end
    // drop enable and flip speed during LED 3: frame completes at the original speed
    @(posedge clock); #1 led_count = 9'd6; speed_sel = 0; enable = 1;
    run_frame(6, 4, 1 + 6 * 96 + RST, 4, 0, w);
    check("mid_wait", w, 0);
    @(negedge clock);
    check("mid_idle_busy", busy, 0);
    check("mid_idle_rd", pix_rd, 0);
    // back-to-back frames with enable held
    @(posedge clock); #1 speed_sel = 0; led_count = 9'd200; enable = 1;
    run_frame(200, 4, 1 + 200 * 96 + RST, -1, 0, w);
    check("b2b_wait", w, 0);
    @(negedge clock);
    check("b2b_rd", pix_rd, 1);
    check("b2b_addr", int'(pix_addr), 0);
    check("b2b_busy", busy, 1);
    // asynchronous reset in the middle of a bit of the second frame
    repeat (40) @(negedge clock);
    w = 0;
    while (serial == 0 && w < 8) begin w++; @(negedge clock); end
    check("pre_rst_serial", int'(serial != 0), 1);
    check("pre_rst_busy", busy, 1);
    #1 reset = 1;
    #1;
    check("async_serial", int'(serial), 0);
    check("async_busy", busy, 0);
    check("async_rd", pix_rd, 0);
    repeat (2) @(posedge clock);
    #1 led_count = 9'd2; reset = 0;
    run_frame(2, 4, 1 + 2 * 96 + RST, -1, 1, w);
    check("restart_wait", w, 0);
    @(negedge clock);
    check("restart_idle", busy, 0);
    // led_count above MAX_LEDS clamps to 256 fetches
    @(posedge clock); #1 led_count = 9'd300; speed_sel = 0; enable = 1;
    run_frame(256, 4, 1 + 256 * 96 + RST, -1, 1, w);
    check("clamp_wait", w, 0);
    @(negedge clock);
    check("clamp_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ws2811_multichannel_driver.md
Name: ws2811_multichannel_driver

Overview:
- Parametrised successor to the single-string WS2811 array controller.
- Drives CHANNELS WS2811 strings in lockstep from one pixel-fetch port. Each channel gets its own 24-bit word per LED index.
- Run-time selectable 800 kHz / 400 kHz bit rate, continuous refresh while enabled, and a frame_done strobe.
- Sits between the frame-buffer RAM (synchronous read, 1-cycle latency) and the LED output pins.

Parameters:
- CHANNELS, 4: number of parallel serial outputs.
- MAX_LEDS, 256: maximum LEDs per string. LED_W = $clog2(MAX_LEDS)+1. ADDR_W = $clog2(MAX_LEDS).
- T0H_CYC, 13: high time of a '0' bit in fast mode, in clock cycles (0.26 us at 50 MHz).
- T1H_CYC, 30: high time of a '1' bit in fast mode (0.60 us).
- TBIT_CYC, 62: total bit period in fast mode (1.24 us).
- RESET_CYC, 2800: low latch time after the last bit (56 us). Not scaled by mode.

Ports:
- clock  in  1  system clock, 50 MHz nominal.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; while high, frames repeat back-to-back.
- led_count  in  LED_W  LEDs per string; sampled at frame start.
- speed_sel  in  1  0 = 800 kHz, 1 = 400 kHz (all bit timings doubled); sampled at frame start.
- pix_rd  out  1  one-cycle read strobe to pixel RAM.
- pix_addr  out  ADDR_W  LED index being fetched.
- pix_data  in  24*CHANNELS  pixel words; channel c uses [24c+23:24c]; valid exactly 1 cycle after pix_rd.
- serial  out  CHANNELS  WS2811 data lines.
- busy  out  1  high from frame start through end of latch.
- frame_done  out  1  one-cycle pulse on the last latch cycle.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset asserted mid-frame forces serial low immediately; no partial-frame recovery.
- FSM states: IDLE, PREFETCH, SEND, LATCH.
- IDLE:
  - If enable=1 and led_count!=0: latch n = min(led_count, MAX_LEDS) and speed_sel; assert pix_rd with pix_addr=0; busy=1; go to PREFETCH.
  - If led_count==0: stay in IDLE, busy=0.
- PREFETCH: one cycle; capture pix_data into the shift registers; go to SEND.
- SEND bit encoding:
  - Each bit lasts TB = TBIT_CYC<<speed_sel cycles, counted 0..TB-1.
  - serial[c] is high while count < (bit ? T1H : T0H)<<speed_sel, then low.
  - 24 bits per LED, MSB first (bit 23 first); all channels share the same bit/cycle counters.
- Gapless prefetch:
  - On cycle 0 of bit 0 of each LED index i < n-1, pulse pix_rd with pix_addr=i+1.
  - Capture pix_data the next cycle into a holding register.
  - Transfer to the shift registers at the boundary into bit 23 of the next LED. No idle cycles between LEDs.
- After bit 0 of LED n-1 completes: go to LATCH with serial=0.
- LATCH: hold serial=0 for RESET_CYC cycles. On the final cycle pulse frame_done.
- After LATCH: if enable=1, start a new frame exactly as IDLE would (busy stays high, pix_rd next cycle); otherwise go to IDLE with busy=0.
- enable deasserted mid-frame: the current frame, including LATCH, completes. enable is only examined in IDLE and at the end of LATCH.
- Changes to led_count or speed_sel mid-frame have no effect until the next frame start.
- led_count > MAX_LEDS is clamped to MAX_LEDS.
- Frame length in cycles = 1 (PREFETCH) + n*24*TB + RESET_CYC, measured from the first pix_rd to the frame_done cycle inclusive.

Test Plan:
- Fast, single pixel: CHANNELS=4, led_count=1, ch0=0xFF0000, ch1=0x00FF00, ch2=0x0000FF, ch3=0xA5A5A5, enable pulsed for 1 cycle -> each line shows 24 bits of 62 cycles each; '1' highs are 30 cycles, '0' highs are 13 cycles; bit patterns match the words MSB first; frame_done exactly 1+1488+2800 cycles after pix_rd.
- Slow mode: speed_sel=1, led_count=2 -> bit period 124 cycles, highs 26/60; pix_addr=1 requested on cycle 0 of bit 0 of LED 0; no gap between LED 0 and LED 1.
- Multi-LED address sequence: led_count=200 with enable held high -> pix_addr walks 0..199 once per frame; frame_done pulses; the next frame starts the cycle after frame_done with pix_addr=0 and busy never drops.
- Boundaries: led_count=0 with enable=1 -> busy=0, no pix_rd, serial=0. led_count=300 with MAX_LEDS=256 -> exactly 256 fetches, last pix_addr=255.
- Mid-frame changes: drop enable and change speed_sel during LED 3 -> current frame finishes at the original speed, frame_done pulses, block returns to IDLE with busy=0.
- Asynchronous reset: assert reset mid-bit during SEND -> serial, busy and pix_rd go to 0 without waiting for a clock edge; after release with enable=1, the frame restarts from pix_addr=0.
